// File: rtl/fft_pkg.sv
// Shared state encoding and the result formatter (optional /2 rounding plus saturation)
// used by the SDF butterfly stage.
package fft_pkg;

  typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

  typedef struct packed {
    logic signed [31:0] val;
    logic               sat;
  } fmt_res_t;

  function automatic fmt_res_t fmt_sat(input logic signed [31:0] v, input logic scale,
                                       input int out_w);
    fmt_res_t r;
    logic signed [31:0] t;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    t  = scale ? ((v + 32'sd1) >>> 1) : v;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (t > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (t < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end else begin
      r.val = t;
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bfly_sdf_stage_if.sv
// Beat-level bus of the SDF butterfly stage: lane data, handshake, control and status.
interface bfly_sdf_stage_if #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 10,
  parameter int NUM       = 16
);
  logic [NUM-1:0][IN_WIDTH-1:0]  din_re;
  logic [NUM-1:0][IN_WIDTH-1:0]  din_im;
  logic                          valid_in;
  logic                          in_ready;
  logic                          cfg_scale;
  logic                          flush;
  logic [NUM-1:0][OUT_WIDTH-1:0] dout_re;
  logic [NUM-1:0][OUT_WIDTH-1:0] dout_im;
  logic                          valid_out;
  logic                          sop_out;
  logic                          ovf;
  logic                          ovf_clr;

  modport master (
    output din_re, din_im, valid_in, cfg_scale, flush, ovf_clr,
    input  in_ready, dout_re, dout_im, valid_out, sop_out, ovf
  );

  modport slave (
    input  din_re, din_im, valid_in, cfg_scale, flush, ovf_clr,
    output in_ready, dout_re, dout_im, valid_out, sop_out, ovf
  );
endinterface

// File: rtl/sdf_delay_line.sv
// Beat-wide feedback delay line: on each enabled cycle the newest beat is written and the
// oldest (DEPTH enabled cycles old) is presented on the read port. Contents are not reset.
module sdf_delay_line #(
  parameter int NUM   = 16,
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  adv_i,
  input  logic [NUM-1:0][W-1:0] wr_re_i,
  input  logic [NUM-1:0][W-1:0] wr_im_i,
  output logic [NUM-1:0][W-1:0] rd_re_o,
  output logic [NUM-1:0][W-1:0] rd_im_o
);
  logic [NUM-1:0][W-1:0] re_q [DEPTH];
  logic [NUM-1:0][W-1:0] im_q [DEPTH];

  // Shift by one slot per enabled cycle; slot DEPTH-1 holds the oldest beat
  always_ff @(posedge clk) begin
    if (adv_i) begin
      re_q[0] <= wr_re_i;
      im_q[0] <= wr_im_i;
      for (int i = 1; i < DEPTH; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end
  end

  assign rd_re_o = re_q[DEPTH-1];
  assign rd_im_o = im_q[DEPTH-1];
endmodule

// File: rtl/bfly_sdf_stage.sv
// Radix-2 DIF single-delay-feedback butterfly stage: first half-frame is stored, second half
// is paired with it; sums leave immediately, differences recirculate and leave a frame later.
module bfly_sdf_stage
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 10,
  parameter int NUM       = 16,
  parameter int HALF      = 16
) (
  input logic              clk,
  input logic              rstn,
  bfly_sdf_stage_if.slave  bus
);
  localparam int          CW       = $clog2(2 * HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] DRN_LAST = CW'(HALF - 1);

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          pending_q, pending_d;
  logic                          scale_q, scale_d;
  logic                          ovf_q, ovf_d;
  logic                          valid_q, valid_d;
  logic                          sop_q, sop_d;
  logic [NUM-1:0][OUT_WIDTH-1:0] dre_q, dre_d, dim_q, dim_d;
  logic [NUM-1:0][OUT_WIDTH-1:0] wr_re_s, wr_im_s, rd_re_s, rd_im_s;
  logic [NUM-1:0][OUT_WIDTH:0]   sre_s, sim_s, dre_s, dim_s;
  logic                          adv_s, phase_b_s, sat_any_s;

  // {sat, value}: sum or difference of the stored sample a and the incoming sample b
  function automatic logic [OUT_WIDTH:0] bfly(input logic [OUT_WIDTH-1:0] a_raw,
                                              input logic [IN_WIDTH-1:0] b_raw,
                                              input logic sub, input logic scale);
    logic signed [IN_WIDTH:0] a;
    logic signed [IN_WIDTH:0] b;
    logic signed [IN_WIDTH:0] v;
    fmt_res_t                 r;
    a = (IN_WIDTH + 1)'($signed(a_raw[IN_WIDTH-1:0]));
    b = (IN_WIDTH + 1)'($signed(b_raw));
    v = sub ? (a - b) : (a + b);
    r = fmt_sat(32'(v), scale, OUT_WIDTH);
    return {r.sat, r.val[OUT_WIDTH-1:0]};
  endfunction

  sdf_delay_line #(.NUM(NUM), .W(OUT_WIDTH), .DEPTH(HALF)) u_dline (
    .clk     (clk),
    .adv_i   (adv_s),
    .wr_re_i (wr_re_s),
    .wr_im_i (wr_im_s),
    .rd_re_o (rd_re_s),
    .rd_im_o (rd_im_s)
  );

  assign phase_b_s = (cnt_q >= CNT_HALF);

  // Per-lane butterfly; only consumed on accepted phase-B beats
  always_comb begin
    sat_any_s = 1'b0;
    for (int l = 0; l < NUM; l++) begin
      sre_s[l]  = bfly(rd_re_s[l], bus.din_re[l], 1'b0, scale_q);
      sim_s[l]  = bfly(rd_im_s[l], bus.din_im[l], 1'b0, scale_q);
      dre_s[l]  = bfly(rd_re_s[l], bus.din_re[l], 1'b1, scale_q);
      dim_s[l]  = bfly(rd_im_s[l], bus.din_im[l], 1'b1, scale_q);
      sat_any_s = sat_any_s | sre_s[l][OUT_WIDTH] | sim_s[l][OUT_WIDTH]
                | dre_s[l][OUT_WIDTH] | dim_s[l][OUT_WIDTH];
    end
  end

  // Next-state and output selection for RUN/DRAIN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    scale_d   = scale_q;
    ovf_d     = ovf_q & ~bus.ovf_clr;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    dre_d     = dre_q;
    dim_d     = dim_q;
    adv_s     = 1'b0;
    wr_re_s   = '0;
    wr_im_s   = '0;
    case (state_q)
      RUN: begin
        if (bus.valid_in) begin
          adv_s     = 1'b1;
          cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
          pending_d = pending_q | (cnt_q == CNT_LAST);
          scale_d   = (cnt_q == '0) ? bus.cfg_scale : scale_q;
          if (phase_b_s) begin
            valid_d = 1'b1;
            sop_d   = (cnt_q == CNT_HALF);
            ovf_d   = ovf_d | sat_any_s;
            for (int l = 0; l < NUM; l++) begin
              dre_d[l]   = sre_s[l][OUT_WIDTH-1:0];
              dim_d[l]   = sim_s[l][OUT_WIDTH-1:0];
              wr_re_s[l] = dre_s[l][OUT_WIDTH-1:0];
              wr_im_s[l] = dim_s[l][OUT_WIDTH-1:0];
            end
          end else begin
            // Oldest entry is last frame's difference; only meaningful while pending
            valid_d = pending_q;
            dre_d   = pending_q ? rd_re_s : dre_q;
            dim_d   = pending_q ? rd_im_s : dim_q;
            for (int l = 0; l < NUM; l++) begin
              wr_re_s[l] = OUT_WIDTH'($signed(bus.din_re[l]));
              wr_im_s[l] = OUT_WIDTH'($signed(bus.din_im[l]));
            end
          end
        end else if (bus.flush && (cnt_q == '0) && pending_q) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        adv_s   = 1'b1;
        valid_d = 1'b1;
        dre_d   = rd_re_s;
        dim_d   = rd_im_s;
        if (cnt_q == DRN_LAST) begin
          cnt_d     = '0;
          pending_d = 1'b0;
          state_d   = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and registered outputs; delay-line contents stay unreset, gated by pending
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      scale_q   <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      dre_q     <= '0;
      dim_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      scale_q   <= scale_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      dre_q     <= dre_d;
      dim_q     <= dim_d;
    end
  end

  assign bus.in_ready  = (state_q == RUN);
  assign bus.dout_re   = dre_q;
  assign bus.dout_im   = dim_q;
  assign bus.valid_out = valid_q;
  assign bus.sop_out   = sop_q;
  assign bus.ovf       = ovf_q;
endmodule
